mem_access_ctrl: RTL

//  Host-side initiator for the bitcell/word memory array. Accepts single-word read/write

---
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the host, the access controller and the word array.
// The slave view belongs to the controller; the master view is the host and array side.
interface mem_access_ctrl_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int NUM_WORDS = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 rsp_err;

  logic                 mem_rw;
  logic [NUM_WORDS-1:0] mem_select;
  logic [DATA_W-1:0]    mem_din;
  logic [DATA_W-1:0]    mem_dout;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rw, mem_select, mem_din
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rw, mem_select, mem_din
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-word read/write initiator for the word array.
// Each access runs SETUP, ACCESS, HOLD and then RESP, so RW and data-in are always stable around the select pulse.
module mem_access_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int NUM_WORDS = 16,
  parameter int WR_PULSE  = 2,
  parameter int RD_WAIT   = 1
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam int MAX_CNT = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam logic [CNT_W-1:0]  WR_LAST    = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0]  RD_LAST    = CNT_W'(RD_WAIT - 1);
  localparam logic [ADDR_W:0]   WORD_LIMIT = (ADDR_W + 1)'(NUM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              accept;
  logic              in_range;
  logic              access_last;

  // The extra top bit keeps the compare valid when every address is implemented.
  assign in_range    = ({1'b0, bus.req_addr} < WORD_LIMIT);
  assign accept      = (state == IDLE) && bus.req_valid;
  assign access_last = (state == ACCESS) && (cnt == (we_q ? WR_LAST : RD_LAST));

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.mem_rw     = 1'b1;
    bus.mem_select = '0;
    bus.mem_din    = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_nxt = in_range ? SETUP : RESP;
        end
      end
      SETUP: begin
        bus.mem_rw  = ~we_q;
        bus.mem_din = we_q ? wdata_q : '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        bus.mem_rw  = ~we_q;
        bus.mem_din = we_q ? wdata_q : '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
          bus.mem_select[i] = (addr_q == ADDR_W'(i));
        end
        if (access_last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        bus.mem_rw  = ~we_q;
        bus.mem_din = we_q ? wdata_q : '0;
        state_nxt   = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read data is sampled on the final ACCESS cycle while select is still high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        err_q   <= ~in_range;
      end
      if ((state == ACCESS) && !access_last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (access_last && !we_q) begin
        rdata_q <= bus.mem_dout;
      end
    end
  end

endmodule
